// File: rtl/seq_pattern_detector_if.sv
// Bundles the configuration, serial stream and status signals of seq_pattern_detector.
// The detector connects through the slave modport and the bit source/status side through master.
interface seq_pattern_detector_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) ();
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               in_bit;
   logic               match;
   logic [CNT_W-1:0]   match_count;
   logic [CNT_W-1:0]   bit_index;
   logic [CNT_W-1:0]   last_match_idx;
   logic               armed;

   modport slave (
      input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
      output match, match_count, bit_index, last_match_idx, armed
   );

   modport master (
      output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
      input  match, match_count, bit_index, last_match_idx, armed
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: compares the newest len accepted bits with a programmable pattern.
// state | meaning: IDLE = no configuration held | FILL = fill < len | TRACK = fill == len
module seq_pattern_detector #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input logic                   clk,
   input logic                   reset,
   seq_pattern_detector_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_TRACK} state_t;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               overlap_q, overlap_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   match_count_q, match_count_d;
   logic [CNT_W-1:0]   bit_index_q, bit_index_d;
   logic [CNT_W-1:0]   last_match_idx_q, last_match_idx_d;

   logic               accept;
   logic               hit;
   logic [LEN_W-1:0]   cfg_len_clamped;
   logic [LEN_W-1:0]   fill_inc;
   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q           <= '0;
         pattern_q        <= '0;
         len_q            <= '0;
         fill_q           <= '0;
         overlap_q        <= 1'b0;
         match_q          <= 1'b0;
         match_count_q    <= '0;
         bit_index_q      <= '0;
         last_match_idx_q <= '0;
      end else begin
         hist_q           <= hist_d;
         pattern_q        <= pattern_d;
         len_q            <= len_d;
         fill_q           <= fill_d;
         overlap_q        <= overlap_d;
         match_q          <= match_d;
         match_count_q    <= match_count_d;
         bit_index_q      <= bit_index_d;
         last_match_idx_q <= last_match_idx_d;
      end
   end

   // Match uses the post-shift history and post-increment fill, so a hit lands on the completing bit.
   always_comb begin
      cfg_len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
      accept          = bus.in_valid && !bus.cfg_load && (state_q != ST_IDLE);
      hist_shift      = {hist_q[MAX_LEN-2:0], bus.in_bit};
      fill_inc        = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
      hit = accept && (fill_inc == len_q) && (((hist_shift ^ pattern_q) & len_mask) == '0);

      hist_d           = hist_q;
      pattern_d        = pattern_q;
      len_d            = len_q;
      fill_d           = fill_q;
      overlap_d        = overlap_q;
      match_d          = 1'b0;
      match_count_d    = match_count_q;
      bit_index_d      = bit_index_q;
      last_match_idx_d = last_match_idx_q;

      if (bus.cfg_load) begin
         pattern_d        = bus.cfg_pattern;
         len_d            = cfg_len_clamped;
         overlap_d        = bus.cfg_overlap;
         hist_d           = '0;
         fill_d           = '0;
         match_count_d    = '0;
         bit_index_d      = '0;
         last_match_idx_d = '0;
      end else if (accept) begin
         hist_d      = hist_shift;
         fill_d      = fill_inc;
         bit_index_d = (bit_index_q == '1) ? bit_index_q : bit_index_q + CNT_W'(1);
         if (hit) begin
            match_d          = 1'b1;
            match_count_d    = (match_count_q == '1) ? match_count_q : match_count_q + CNT_W'(1);
            last_match_idx_d = bit_index_q;
            if (!overlap_q) begin
               fill_d = '0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.cfg_load) begin
         state_d = (cfg_len_clamped == '0) ? ST_IDLE : ST_FILL;
      end else if (accept) begin
         if (hit && !overlap_q) begin
            state_d = ST_FILL;
         end else if (fill_inc == len_q) begin
            state_d = ST_TRACK;
         end else begin
            state_d = ST_FILL;
         end
      end
   end

   always_comb begin
      bus.match          = match_q;
      bus.match_count    = match_count_q;
      bus.bit_index      = bit_index_q;
      bus.last_match_idx = last_match_idx_q;
      bus.armed          = (state_q != ST_IDLE);
   end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Drives two detectors (CNT_W=16 and CNT_W=2) with the same stream and checks both
// every cycle against a queue-based window model, plus literal checks for known streams.
module tb_seq_pattern_detector;
   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;

   seq_pattern_detector_if #(.MAX_LEN(8), .CNT_W(16)) if_a ();
   seq_pattern_detector_if #(.MAX_LEN(8), .CNT_W(2))  if_b ();

   assign if_a.cfg_load    = cfg_load;
   assign if_a.cfg_pattern = cfg_pattern;
   assign if_a.cfg_len     = cfg_len;
   assign if_a.cfg_overlap = cfg_overlap;
   assign if_a.in_valid    = in_valid;
   assign if_a.in_bit      = in_bit;
   assign if_b.cfg_load    = cfg_load;
   assign if_b.cfg_pattern = cfg_pattern;
   assign if_b.cfg_len     = cfg_len;
   assign if_b.cfg_overlap = cfg_overlap;
   assign if_b.in_valid    = in_valid;
   assign if_b.in_bit      = in_bit;

   seq_pattern_detector #(.MAX_LEN(8), .CNT_W(16)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
   seq_pattern_detector #(.MAX_LEN(8), .CNT_W(2))  u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Model: a window of bits received since the last restart point; oldest bit first.
   bit         m_armed;
   int         m_len;
   logic [7:0] m_pat;
   bit         m_ovl;
   bit         m_win[$];
   int         m_nbits, m_nmatch, m_last, m_idx;
   bit         m_pulse, m_eq;
   int         m_hits[$];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_armed = 0; m_len = 0; m_pat = '0; m_ovl = 0;
         m_win.delete(); m_hits.delete();
         m_nbits = 0; m_nmatch = 0; m_last = 0; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (cfg_load) begin
            m_len   = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
            m_pat   = cfg_pattern;
            m_ovl   = cfg_overlap;
            m_armed = (m_len != 0);
            m_win.delete(); m_hits.delete();
            m_nbits = 0; m_nmatch = 0; m_last = 0;
         end else if (in_valid && m_armed) begin
            m_idx = m_nbits;
            m_nbits++;
            m_win.push_back(in_bit);
            if (m_win.size() > m_len) void'(m_win.pop_front());
            if (m_win.size() == m_len) begin
               m_eq = 1;
               for (int k = 0; k < m_len; k++)
                  if (m_win[k] != m_pat[m_len-1-k]) m_eq = 0;
               if (m_eq) begin
                  m_pulse = 1;
                  m_nmatch++;
                  m_last = m_idx;
                  m_hits.push_back(m_idx);
                  if (!m_ovl) m_win.delete();
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("match_a",  {31'd0, if_a.match},  {31'd0, m_pulse});
      check("count_a",  {16'd0, if_a.match_count},    sat(m_nmatch, 65535));
      check("index_a",  {16'd0, if_a.bit_index},      sat(m_nbits, 65535));
      check("last_a",   {16'd0, if_a.last_match_idx}, sat(m_last, 65535));
      check("armed_a",  {31'd0, if_a.armed},  {31'd0, m_armed});
      check("match_b",  {31'd0, if_b.match},  {31'd0, m_pulse});
      check("count_b",  {30'd0, if_b.match_count},    sat(m_nmatch, 3));
      check("index_b",  {30'd0, if_b.bit_index},      sat(m_nbits, 3));
      check("last_b",   {30'd0, if_b.last_match_idx}, sat(m_last, 3));
      check("armed_b",  {31'd0, if_b.armed},  {31'd0, m_armed});
   end

   task automatic do_load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic iv = 1'b0, input logic ib = 1'b0);
      cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      in_valid = iv; in_bit = ib;
      @(posedge clk); #1;
      cfg_load = 1'b0; in_valid = 1'b0;
      cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
   endtask

   task automatic send_bits(input logic [63:0] v, input int n, input int gap);
      for (int i = n - 1; i >= 0; i--) begin
         in_valid = 1'b1; in_bit = v[i];
         @(posedge clk); #1;
         in_valid = 1'b0; in_bit = 1'($urandom);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic hit_at(input string name, input int pos, input int exp);
      check(name, (m_hits.size() > pos) ? m_hits[pos] : -1, exp);
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_armed", {31'd0, if_a.armed}, 0);
      check("rst_count", {16'd0, if_a.match_count}, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Scenario: 110 overlapping on a continuous stream
      do_load(8'b0000_0110, 4'd3, 1'b1);
      send_bits(64'b111010111000110, 15, 0);
      check("s1_pulse", {31'd0, if_a.match}, 1);
      check("s1_count", {16'd0, if_a.match_count}, 3);
      check("s1_index", {16'd0, if_a.bit_index}, 15);
      check("s1_last",  {16'd0, if_a.last_match_idx}, 14);
      hit_at("s1_hit0", 0, 3);
      hit_at("s1_hit1", 1, 9);
      hit_at("s1_hit2", 2, 14);

      // Scenario: 101 overlapping vs non-overlapping
      do_load(8'b0000_0101, 4'd3, 1'b1);
      send_bits(64'b10101, 5, 0);
      check("s2o_count", {16'd0, if_a.match_count}, 2);
      check("s2o_last",  {16'd0, if_a.last_match_idx}, 4);
      do_load(8'b0000_0101, 4'd3, 1'b0);
      send_bits(64'b10101, 5, 0);
      check("s2n_count", {16'd0, if_a.match_count}, 1);
      check("s2n_last",  {16'd0, if_a.last_match_idx}, 2);

      // Scenario: gaps of 3 idle cycles between bits
      do_load(8'b0000_0110, 4'd3, 1'b1);
      send_bits(64'b111010111000110, 15, 3);
      check("s3_count", {16'd0, if_a.match_count}, 3);
      check("s3_index", {16'd0, if_a.bit_index}, 15);
      hit_at("s3_hit0", 0, 3);
      hit_at("s3_hit1", 1, 9);
      hit_at("s3_hit2", 2, 14);

      // Scenario: len=1 saturation on the narrow instance
      do_load(8'b0000_0001, 4'd1, 1'b0);
      send_bits(64'b11111, 5, 0);
      check("s4_pulse_b", {31'd0, if_b.match}, 1);
      check("s4_count_b", {30'd0, if_b.match_count}, 3);
      check("s4_index_b", {30'd0, if_b.bit_index}, 3);
      check("s4_count_a", {16'd0, if_a.match_count}, 5);

      // Scenario: asynchronous reset mid-cycle after bit 8
      do_load(8'b0000_0110, 4'd3, 1'b1);
      send_bits(64'b111010111, 9, 0);
      check("s5_pre_count", {16'd0, if_a.match_count}, 1);
      #2 reset = 1'b0;
      #1;
      check("s5_match", {31'd0, if_a.match}, 0);
      check("s5_count", {16'd0, if_a.match_count}, 0);
      check("s5_index", {16'd0, if_a.bit_index}, 0);
      check("s5_last",  {16'd0, if_a.last_match_idx}, 0);
      check("s5_armed", {31'd0, if_a.armed}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      send_bits(64'b000110110, 9, 0);
      check("s5_post_count", {16'd0, if_a.match_count}, 0);
      check("s5_post_armed", {31'd0, if_a.armed}, 0);

      // Scenario: len=0, clamped len, load colliding with data
      do_load(8'b0000_0000, 4'd0, 1'b1);
      send_bits(64'b0000_0000_0101_1100_0110, 20, 0);
      check("s6_len0_armed", {31'd0, if_a.armed}, 0);
      check("s6_len0_count", {16'd0, if_a.match_count}, 0);
      do_load(8'b1011_0011, 4'd12, 1'b1);
      send_bits(64'b1011_0011, 8, 0);
      check("s6_clamp_count", {16'd0, if_a.match_count}, 1);
      check("s6_clamp_last",  {16'd0, if_a.last_match_idx}, 7);
      do_load(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b1);
      check("s6_collide_index", {16'd0, if_a.bit_index}, 0);
      check("s6_collide_armed", {31'd0, if_a.armed}, 1);

      // Randomized configurations and streams
      for (int r = 0; r < 40; r++) begin
         logic [3:0] len;
         len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 3));
         do_load(8'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom));
         for (int c = 0; c < 60; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit   = 1'($urandom);
            @(posedge clk); #1;
            if (r == 20 && c == 30) begin
               #3 reset = 1'b0;
               @(posedge clk); #1;
               reset = 1'b1;
            end
         end
         in_valid = 1'b0;
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL timeout: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end
endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Streaming serial pattern detector; next generation of the team's fixed "110" detector.
- Accepts one bit per cycle under a valid qualifier and compares the most recent cfg_len bits against a runtime-programmable pattern of up to MAX_LEN bits.
- Match mode is selectable: overlapping or non-overlapping.
- Outputs a one-cycle match pulse, a saturating match counter and the stream index of the last match; sits between a serial bit source and a status/interrupt block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2)
- CNT_W, 16, width of match_count, bit_index and last_match_idx
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- cfg_load  input  1  latch the configuration and restart detection
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
- cfg_len  input  LEN_W  pattern length; 0 disables the detector
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- in_valid  input  1  in_bit is presented this cycle
- in_bit  input  1  serial data bit
- match  output  1  registered one-cycle pulse on pattern completion
- match_count  output  CNT_W  number of matches since load/reset; saturates at all-ones
- bit_index  output  CNT_W  number of bits accepted since load/reset; saturates at all-ones
- last_match_idx  output  CNT_W  bit_index value of the completing bit of the most recent match
- armed  output  1  1 when a valid configuration is held (state is not IDLE)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; outputs match, match_count, bit_index, last_match_idx and armed are 0; history, fill, pattern, len and overlap registers are 0.
- States:
  - IDLE: no configuration; in_valid is ignored.
  - FILL: fill < len.
  - TRACK: fill == len.
- cfg_load=1 at an edge:
  - Latches pattern, len and overlap.
  - Clears history, fill, match, match_count, bit_index and last_match_idx.
  - in_valid is ignored on that edge; cfg_load has priority over data.
  - Next state: IDLE if cfg_len=0, else FILL.
  - cfg_len > MAX_LEN is clamped to MAX_LEN.
  - Configuration inputs are don't-care while cfg_load=0.
- Accepted bit: in_valid=1, cfg_load=0 and state is not IDLE.
  - Shift history: hist <= {hist[MAX_LEN-2:0], in_bit}; hist[0] is the newest bit.
  - fill increments, capped at len.
  - bit_index increments (saturating). The first accepted bit has index 0: the index of the completing bit is the pre-increment bit_index value.
- Match condition: evaluated on the post-shift history and post-increment fill: fill_next == len and hist_next[len-1:0] == pattern[len-1:0].
- On a match:
  - match=1 for exactly the cycle following the accepting edge (latency 1).
  - match_count increments, saturating at 2^CNT_W-1.
  - last_match_idx <= index of the completing bit.
  - If overlap=0: fill <= 0 and state returns to FILL. If overlap=1: fill stays at len and state stays TRACK.
- In all other cycles match=0.
- When in_valid=0: history, fill, counters and state hold; match deasserts.
- FILL->TRACK when fill reaches len without a match; TRACK->FILL only on a non-overlap match.
- Reset mid-stream: immediate return to IDLE and all outputs 0; a cfg_load is required before detection resumes.
- len=1: every accepted bit equal to pattern[0] is a match in both modes.

Test Plan:
- Load pattern=110 (cfg_pattern=8'b0000_0110), len=3, overlap=1; feed 111010111000110 first bit first, in_valid=1 continuously -> match pulses after bit indices 3, 9, 14; match_count=3; last_match_idx=14; bit_index=15.
- Load 101, len=3; feed 10101 -> overlap=1: matches at indices 2 and 4, count=2; overlap=0: single match at index 2, count=1.
- Pattern 110 stream with in_valid deasserted for 3 cycles between every bit -> same match indices as scenario 1, each pulse exactly one cycle wide, no state change during gaps.
- CNT_W=2, pattern=1, len=1; feed 5 ones -> match pulses on all 5 bits; match_count saturates at 3; bit_index saturates at 3.
- Assert reset low asynchronously (mid-cycle) after bit 8 of scenario 1 -> all outputs 0 immediately; armed=0; further bits produce no match until cfg_load.
- cfg_load with len=0 -> armed=0 and no matches on any stream; cfg_load with len=12 while MAX_LEN=8 -> behaves as len=8; cfg_load coincident with in_valid=1 -> that bit is dropped and bit_index=0.
